// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: the state encoding,
// the default bit period, and a frame-length helper. The future receiver
// is expected to reuse these definitions.
package uart_pkg;

  // Transmitter states, 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_START  = 3'd3,
    ST_DATA   = 3'd4,
    ST_PARITY = 3'd5,
    ST_STOP   = 3'd6
  } tx_state_t;

  // 100 MHz system clock divided down to 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Clock cycles from the falling start-bit edge to the return to idle
  function automatic int frame_cycles(input int clks_per_bit,
                                      input int parity_en,
                                      input int stop_bits);
    return (10 + parity_en + stop_bits - 1) * clks_per_bit;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer. Counts 0..TERMINAL-1 and raises tick during the last
// cycle of each period, wrapping back to zero on the following edge.
// Holding clear keeps the count at zero so a period starts cleanly.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int TERMINAL = DEFAULT_CLKS_PER_BIT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int WIDTH = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

  logic [WIDTH-1:0] count;

  assign tick = (count == WIDTH'(TERMINAL - 1));

  // Free-running period counter, held at zero while cleared
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains a byte FIFO. Each frame pops exactly one
// byte and sends start, 8 data bits LSB first, optional parity, and one
// or two stop bits. Every output is a flop; the comb process only
// computes next values.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_enable,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_read,
  output logic       tx,
  output logic       busy
);

  localparam logic USE_PARITY = (PARITY_EN != 0);
  localparam logic ODD_BIT    = (PARITY_ODD != 0);
  localparam logic TWO_STOP   = (STOP_BITS == 2);

  tx_state_t  state, state_next;
  logic [7:0] shift_reg, shift_next;
  logic       parity_acc, parity_next;
  logic [2:0] bit_idx, bit_next;
  logic       stop_idx, stop_next;
  logic       tx_next, read_next, busy_next;
  logic       baud_clear, bit_tick;

  // The bit timer only runs while a frame is on the line
  assign baud_clear = (state == ST_IDLE) || (state == ST_FETCH) || (state == ST_LOAD);

  uart_baud_counter #(
    .TERMINAL(CLKS_PER_BIT)
  ) baud (
    .clock(clock),
    .reset(reset),
    .clear(baud_clear),
    .tick (bit_tick)
  );

  // Next-state and next-output logic; registered below
  always_comb begin
    state_next  = state;
    shift_next  = shift_reg;
    parity_next = parity_acc;
    bit_next    = bit_idx;
    stop_next   = stop_idx;
    tx_next     = tx;
    busy_next   = busy;
    read_next   = 1'b0;

    case (state)
      ST_IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (tx_enable && !fifo_empty) begin
          state_next = ST_FETCH;
          read_next  = 1'b1;
          busy_next  = 1'b1;
        end
      end

      ST_FETCH: begin
        state_next = ST_LOAD;
      end

      ST_LOAD: begin
        shift_next  = fifo_data;
        parity_next = ^fifo_data;
        bit_next    = 3'd0;
        stop_next   = 1'b0;
        tx_next     = 1'b0;
        state_next  = ST_START;
      end

      ST_START: begin
        if (bit_tick) begin
          tx_next    = shift_reg[0];
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = 3'd0;
          state_next = ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          if (bit_idx == 3'd7) begin
            bit_next  = 3'd0;
            stop_next = 1'b0;
            if (USE_PARITY) begin
              tx_next    = parity_acc ^ ODD_BIT;
              state_next = ST_PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = ST_STOP;
            end
          end else begin
            tx_next    = shift_reg[0];
            shift_next = {1'b0, shift_reg[7:1]};
            bit_next   = bit_idx + 3'd1;
          end
        end
      end

      ST_PARITY: begin
        if (bit_tick) begin
          tx_next    = 1'b1;
          stop_next  = 1'b0;
          state_next = ST_STOP;
        end
      end

      ST_STOP: begin
        tx_next = 1'b1;
        if (bit_tick) begin
          if (!TWO_STOP || stop_idx) begin
            stop_next  = 1'b0;
            busy_next  = 1'b0;
            state_next = ST_IDLE;
          end else begin
            stop_next = 1'b1;
          end
        end
      end

      default: begin
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any byte in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      shift_reg  <= 8'd0;
      parity_acc <= 1'b0;
      bit_idx    <= 3'd0;
      stop_idx   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      fifo_read  <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      parity_acc <= parity_next;
      bit_idx    <= bit_next;
      stop_idx   <= stop_next;
      tx         <= tx_next;
      busy       <= busy_next;
      fifo_read  <= read_next;
    end
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
Serial transmitter stage directly downstream of the byte FIFO buffer. It pops bytes from the FIFO one at a time and shifts each out on a single UART TX line. Frame format is start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits. It is the outbound end of the FPGA-to-host link.

Parameters:
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range 2..65535
PARITY_EN, 0, 1 = insert a parity bit after the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clock  input  1  system clock; all logic on its rising edge
reset  input  1  synchronous, active-high reset
tx_enable  input  1  permit starting a new frame; sampled only in IDLE
fifo_data  input  8  FIFO read data; valid the cycle after fifo_read is high
fifo_empty  input  1  FIFO empty flag
fifo_read  output  1  one-cycle pop strobe to the FIFO
tx  output  1  serial line, idles high
busy  output  1  high from FETCH through the last stop-bit cycle

Behaviour:
- Reset (synchronous, any state): tx=1, fifo_read=0, busy=0, state=IDLE, baud counter=0, bit index=0. A byte in flight is abandoned and lost. tx reads 1 from the edge that samples reset.
- All outputs are registered. There is no combinational path from input to output.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1, busy=0. At an edge with tx_enable=1 and fifo_empty=0, go to FETCH, drive fifo_read=1, busy=1.
- FETCH: lasts exactly one cycle with fifo_read=1. At the next edge, fifo_read=0 and go to LOAD.
- LOAD: at the next edge, shift_reg <= fifo_data, parity_acc <= ^fifo_data, tx <= 0, go to START.
- Latency: if the IDLE condition is sampled at edge k, tx falls at edge k+2.
- fifo_read is never asserted as a result of a sample where fifo_empty=1. At most one pop per frame.
- Baud counter counts 0..CLKS_PER_BIT-1. Its width is clog2(CLKS_PER_BIT). Each bit is held exactly CLKS_PER_BIT cycles, and the state or bit advances when the counter reaches CLKS_PER_BIT-1, where the counter wraps to 0.
- START: tx=0 for one bit time, then DATA.
- DATA: tx=shift_reg[0]; shift right once per bit. After bit index 7 completes, go to PARITY if PARITY_EN, else STOP. Bit index wraps 7->0.
- PARITY: tx = parity_acc ^ PARITY_ODD for one bit time.
- STOP: tx=1 for STOP_BITS bit times, then IDLE with busy=0.
- Frame length: (10 + PARITY_EN + STOP_BITS - 1) x CLKS_PER_BIT cycles from the tx fall to the IDLE entry.
- Back-to-back frames: when re-entering IDLE with a non-empty FIFO, the earliest next tx fall is 3 cycles later. tx stays high in between.
- tx_enable deasserted mid-frame: the current frame completes normally. No new frame starts until it is reasserted.
- FIFO becomes empty or gets written mid-frame: no effect until IDLE.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding constants (3-bit, IDLE=0 ... STOP=6);
  - the default CLKS_PER_BIT;
  - the frame-length helper function.
- One natural sub-module: uart_baud_counter. It has a parameterised terminal count, a clear input and a tick output, and is reused by the future receiver.

Test Plan:
- CLKS_PER_BIT=4, FIFO holds 0x55, tx_enable=1 -> fifo_read pulses 1 cycle; the tx bit sequence is 0,1,0,1,0,1,0,1,0,1, each bit exactly 4 cycles; busy falls after 40 cycles of frame; exactly one pop.
- PARITY_EN=1, PARITY_ODD=0, byte 0xA7 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame length is 44 cycles at CLKS_PER_BIT=4.
- FIFO holds 0x01,0x80, STOP_BITS=2 -> two frames, each with 2 stop bits of 4 cycles; an inter-frame gap of exactly 3 extra high cycles; data arrives in order.
- fifo_empty=1 with tx_enable=1 for 100 cycles -> fifo_read never asserts, tx stays 1, busy stays 0; set tx_enable=0 with a non-empty FIFO -> no pop.
- Assert reset for 1 cycle during DATA bit 3 -> tx=1, busy=0, fifo_read=0 at the next edge; after release, the next byte is popped and sent with a correct full frame.
- Deassert tx_enable mid-frame -> the frame completes intact and no further pop occurs; reassert -> the next frame starts with tx falling 2 edges after the sampling edge.
